player_controller: RTL and testbench

- Per-player movement and action engine; consumes the debounced button levels and the carry switch produced by the top-level input stage.
- Converts held buttons into discrete grid moves with auto-repeat.
- Checks each target tile against the game grid through a one-cycle query handshake.
- Tracks facing direction and times chop actions.
- Outputs (location, direction, state, chop_done) feed game logic and graphics.

---
 rtl/player_controller.sv | 160 ++++++++++++++++
 tb/tb_player_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_controller.sv
// Per-player movement/action engine: held buttons become grid moves with auto-repeat,
// each target is checked against the grid through a one-cycle query, and chop holds are timed.
module player_controller #(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 12,
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int CHOP_CYCLES   = 50000000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       chop_in,
  input  logic       carry_in,
  output logic       query_valid,
  output logic [3:0] query_x,
  output logic [3:0] query_y,
  input  logic       blocked_in,
  output logic [3:0] player_x,
  output logic [3:0] player_y,
  output logic [1:0] player_dir,
  output logic [1:0] player_state,
  output logic       chop_done,
  output logic       bump
);

  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int CW = (CHOP_CYCLES > 2) ? $clog2(CHOP_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CHOP_LAST = CW'(CHOP_CYCLES - 1);

  typedef enum logic {READY = 1'b0, CHECK = 1'b1} fsm_t;
  fsm_t fsm, fsm_next;

  logic [3:0]        dir_lvl, dir_prev, dir_req;
  logic [RW-1:0]     rep_cnt [4];
  logic [CW-1:0]     chop_cnt;
  logic              chop_active, move, oob;
  logic [1:0]        req_dir, state_next;
  logic signed [4:0] tgt_x, tgt_y;

  // Bit order doubles as direction code and request priority: up, down, left, right.
  assign dir_lvl     = {right_in, left_in, down_in, up_in};
  assign chop_active = chop_in && !carry_in && (fsm == READY);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dir_req[i] = dir_lvl[i] && (!dir_prev[i] || (rep_cnt[i] == REP_LAST));
    end
  end

  always_comb begin
    req_dir = 2'd3;
    if (dir_req[0])      req_dir = 2'd0;
    else if (dir_req[1]) req_dir = 2'd1;
    else if (dir_req[2]) req_dir = 2'd2;
    move = (|dir_req) && (fsm == READY) && !chop_active;
  end

  always_comb begin
    tgt_x = $signed({1'b0, player_x});
    tgt_y = $signed({1'b0, player_y});
    case (req_dir)
      2'd0:    tgt_y = tgt_y - 5'sd1;
      2'd1:    tgt_y = tgt_y + 5'sd1;
      2'd2:    tgt_x = tgt_x - 5'sd1;
      default: tgt_x = tgt_x + 5'sd1;
    endcase
    oob = tgt_x[4] || tgt_y[4] || (int'(tgt_x) >= GRID_W) || (int'(tgt_y) >= GRID_H);
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      READY:   if (move && !oob) fsm_next = CHECK;
      CHECK:   fsm_next = READY;
      default: fsm_next = READY;
    endcase
  end

  // Registered state: reports "moving" from the cycle the query issues through the position update.
  always_comb begin
    state_next = 2'd0;
    if (fsm_next == CHECK || fsm == CHECK) state_next = 2'd1;
    else if (chop_active)                  state_next = 2'd2;
    else if (carry_in)                     state_next = 2'd3;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      fsm <= READY;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      dir_prev     <= '0;
      for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
      chop_cnt     <= '0;
      chop_done    <= 1'b0;
      query_valid  <= 1'b0;
      query_x      <= 4'(START_X);
      query_y      <= 4'(START_Y);
      bump         <= 1'b0;
      player_x     <= 4'(START_X);
      player_y     <= 4'(START_Y);
      player_dir   <= 2'd1;
      player_state <= 2'd0;
    end else begin
      dir_prev     <= dir_lvl;
      chop_done    <= 1'b0;
      query_valid  <= 1'b0;
      bump         <= 1'b0;
      player_state <= state_next;

      for (int i = 0; i < 4; i++) begin
        if (!dir_lvl[i] || dir_req[i]) rep_cnt[i] <= '0;
        else                           rep_cnt[i] <= rep_cnt[i] + RW'(1);
      end

      if (!chop_in || carry_in) begin
        chop_cnt <= '0;
      end else if (chop_active) begin
        if (chop_cnt == CHOP_LAST) begin
          chop_cnt  <= '0;
          chop_done <= 1'b1;
        end else begin
          chop_cnt <= chop_cnt + CW'(1);
        end
      end

      if (move) begin
        player_dir <= req_dir;
        if (oob) begin
          bump <= 1'b1;
        end else begin
          query_x     <= tgt_x[3:0];
          query_y     <= tgt_y[3:0];
          query_valid <= 1'b1;
        end
      end

      if (fsm == CHECK) begin
        if (blocked_in) begin
          bump <= 1'b1;
        end else begin
          player_x <= query_x;
          player_y <= query_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller on a 4x4 grid with short repeat/chop periods.
module tb_player_controller;

  logic clk = 1'b0;
  logic rst, left, right, up, down, chop, carry, blocked;
  logic       query_valid, chop_done, bump;
  logic [3:0] query_x, query_y, player_x, player_y;
  logic [1:0] player_dir, player_state;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } tgt_t;

  tgt_t exp_q[$];
  int   exp_c[$];
  int   checks = 0;
  int   passed = 0;

  player_controller #(
    .GRID_W(4), .GRID_H(4), .START_X(1), .START_Y(1),
    .REPEAT_CYCLES(8), .CHOP_CYCLES(5)
  ) dut (
    .clock_in(clk), .reset_in(rst),
    .left_in(left), .right_in(right), .up_in(up), .down_in(down),
    .chop_in(chop), .carry_in(carry),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .blocked_in(blocked),
    .player_x(player_x), .player_y(player_y),
    .player_dir(player_dir), .player_state(player_state),
    .chop_done(chop_done), .bump(bump)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b1; left = 0; right = 0; up = 0; down = 0; chop = 0; carry = 0; blocked = 0;
    #3;
    got = {player_x, player_y, player_dir, player_state, query_valid, bump, chop_done};
    checks++;
    if (got !== {4'd1, 4'd1, 2'd1, 2'd0, 3'b000}) $display("FAIL reset_async got=%h exp=%h", got, {4'd1, 4'd1, 2'd1, 2'd0, 3'b000});
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {player_x, player_y, player_dir, player_state, query_valid, bump, chop_done};
    checks++;
    if (got !== {4'd1, 4'd1, 2'd1, 2'd0, 3'b000}) $display("FAIL reset_idle got=%h exp=%h", got, {4'd1, 4'd1, 2'd1, 2'd0, 3'b000});
    else passed++;
  endtask

  task automatic test_move_right();
    tgt_t e;
    logic [10:0] got;
    @(negedge clk);
    right = 1'b1;
    exp_q.push_back({4'd2, 4'd1});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      right = 1'b0;
      if (query_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL move_right_query unexpected got=(%0d,%0d)", query_x, query_y);
        else begin
          e = exp_q.pop_front();
          if ({query_x, query_y} !== e) $display("FAIL move_right_query got=(%0d,%0d) exp=(%0d,%0d)", query_x, query_y, e.x, e.y);
          else passed++;
        end
      end
      got = {query_valid, player_x, player_dir, player_state};
      checks++;
      case (k)
        1: if (got !== {1'b1, 4'd1, 2'd3, 2'd1}) $display("FAIL move_right_c1 got=%h exp=%h", got, {1'b1, 4'd1, 2'd3, 2'd1}); else passed++;
        2: if (got !== {1'b0, 4'd2, 2'd3, 2'd1}) $display("FAIL move_right_c2 got=%h exp=%h", got, {1'b0, 4'd2, 2'd3, 2'd1}); else passed++;
        default: if (got !== {1'b0, 4'd2, 2'd3, 2'd0}) $display("FAIL move_right_c3 got=%h exp=%h", got, {1'b0, 4'd2, 2'd3, 2'd0}); else passed++;
      endcase
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL move_right_pending got=%0d exp=0", exp_q.size());
    else passed++;
  endtask

  task automatic test_edge_bump();
    tgt_t e;
    int nb = 0;
    logic [9:0] got;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      left = 1'b1;
      if (p < 2) exp_q.push_back({4'(1 - p), 4'd1});
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        left = 1'b0;
        if (bump) nb++;
        if (query_valid) begin
          checks++;
          if (exp_q.size() == 0) $display("FAIL edge_query unexpected got=(%0d,%0d)", query_x, query_y);
          else begin
            e = exp_q.pop_front();
            if ({query_x, query_y} !== e) $display("FAIL edge_query got=(%0d,%0d) exp=(%0d,%0d)", query_x, query_y, e.x, e.y);
            else passed++;
          end
        end
      end
    end
    checks++;
    if (nb != 1) $display("FAIL edge_bump_count got=%0d exp=1", nb);
    else passed++;
    got = {player_x, player_y, player_dir};
    checks++;
    if (got !== {4'd0, 4'd1, 2'd2} || exp_q.size() != 0) $display("FAIL edge_pos got=%h exp=%h pending=%0d", got, {4'd0, 4'd1, 2'd2}, exp_q.size());
    else passed++;
  endtask

  task automatic test_blocked();
    tgt_t e;
    int nb = 0;
    logic [9:0] got;
    @(negedge clk);
    right = 1'b1;
    exp_q.push_back({4'd1, 4'd1});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bump) nb++;
      if (query_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL blocked_query unexpected got=(%0d,%0d)", query_x, query_y);
        else begin
          e = exp_q.pop_front();
          if ({query_x, query_y} !== e) $display("FAIL blocked_query got=(%0d,%0d) exp=(%0d,%0d)", query_x, query_y, e.x, e.y);
          else passed++;
        end
      end
      right = 1'b0;
      up = 1'b0;
      if (k == 3) begin
        blocked = 1'b1;
        up = 1'b1;
        exp_q.push_back({4'd1, 4'd0});
      end
    end
    blocked = 1'b0;
    checks++;
    if (nb != 1) $display("FAIL blocked_bump_count got=%0d exp=1", nb);
    else passed++;
    got = {player_x, player_y, player_dir};
    checks++;
    if (got !== {4'd1, 4'd1, 2'd0} || exp_q.size() != 0) $display("FAIL blocked_pos got=%h exp=%h pending=%0d", got, {4'd1, 4'd1, 2'd0}, exp_q.size());
    else passed++;
  endtask

  task automatic test_hold_repeat();
    tgt_t e;
    int nb = 0;
    int bump_cyc = -1;
    @(negedge clk);
    down = 1'b1;
    exp_q.push_back({4'd1, 4'd2});
    exp_q.push_back({4'd1, 4'd3});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bump) begin nb++; bump_cyc = k; end
      if (query_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL hold_query unexpected cyc=%0d got=(%0d,%0d)", k, query_x, query_y);
        else begin
          e = exp_q.pop_front();
          if ({query_x, query_y} !== e) $display("FAIL hold_query cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", k, query_x, query_y, e.x, e.y);
          else passed++;
        end
      end
      if (k == 2 || k == 9 || k == 10) begin
        checks++;
        if (player_y !== ((k == 10) ? 4'd3 : 4'd2)) $display("FAIL hold_y cyc=%0d got=%0d exp=%0d", k, player_y, (k == 10) ? 3 : 2);
        else passed++;
      end
    end
    down = 1'b0;
    checks++;
    if (nb != 1 || bump_cyc != 17) $display("FAIL hold_bump got=%0d@%0d exp=1@17", nb, bump_cyc);
    else passed++;
    checks++;
    if ({player_x, player_y, player_dir} !== {4'd1, 4'd3, 2'd1} || exp_q.size() != 0)
      $display("FAIL hold_final got=(%0d,%0d) dir=%0d exp=(1,3) dir=1 pending=%0d", player_x, player_y, player_dir, exp_q.size());
    else passed++;
  endtask

  task automatic test_chop();
    int c;
    @(negedge clk);
    chop = 1'b1;
    carry = 1'b0;
    exp_c.push_back(5);
    exp_c.push_back(10);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (chop_done) begin
        checks++;
        if (exp_c.size() == 0) $display("FAIL chop_done unexpected cyc=%0d", k);
        else begin
          c = exp_c.pop_front();
          if (c != k) $display("FAIL chop_done_cycle got=%0d exp=%0d", k, c);
          else passed++;
        end
      end
      if (query_valid) begin
        checks++;
        $display("FAIL chop_query unexpected cyc=%0d got=(%0d,%0d)", k, query_x, query_y);
      end
      if (k == 3) begin
        checks++;
        if (player_state !== 2'd2) $display("FAIL chop_state got=%0d exp=2", player_state);
        else passed++;
      end
      if (k == 9) begin
        checks++;
        if ({player_x, player_y, player_dir} !== {4'd1, 4'd3, 2'd1})
          $display("FAIL chop_move_ignored got=(%0d,%0d) dir=%0d exp=(1,3) dir=1", player_x, player_y, player_dir);
        else passed++;
      end
      if (k == 24) begin
        checks++;
        if (player_state !== 2'd3) $display("FAIL carry_state got=%0d exp=3", player_state);
        else passed++;
      end
      if (k == 6) left = 1'b1;
      if (k == 7) left = 1'b0;
      if (k == 12) carry = 1'b1;
    end
    checks++;
    if (exp_c.size() != 0) $display("FAIL chop_missing got=%0d exp=0 pending pulses", exp_c.size());
    else passed++;
    chop = 1'b0;
    carry = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_check();
    tgt_t e;
    logic [16:0] got;
    int nq = 0;
    @(negedge clk);
    up = 1'b1;
    exp_q.push_back({4'd1, 4'd2});
    @(negedge clk);
    up = 1'b0;
    checks++;
    if (!query_valid || exp_q.size() == 0) $display("FAIL rst_check_query got=%b exp=1", query_valid);
    else begin
      e = exp_q.pop_front();
      if ({query_x, query_y} !== e) $display("FAIL rst_check_query got=(%0d,%0d) exp=(%0d,%0d)", query_x, query_y, e.x, e.y);
      else passed++;
    end
    #1 rst = 1'b1;
    #1;
    got = {player_x, player_y, player_dir, player_state, query_valid, bump, chop_done};
    checks++;
    if (got !== {4'd1, 4'd1, 2'd1, 2'd0, 3'b000}) $display("FAIL rst_mid_check got=%h exp=%h", got, {4'd1, 4'd1, 2'd1, 2'd0, 3'b000});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (query_valid || bump) nq++;
    end
    checks++;
    if (nq != 0 || {player_x, player_y} !== {4'd1, 4'd1})
      $display("FAIL rst_after got=(%0d,%0d) events=%0d exp=(1,1) events=0", player_x, player_y, nq);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_edge_bump();
    test_blocked();
    test_hold_repeat();
    test_chop();
    test_reset_mid_check();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
